alu_rs: RTL

- Reservation station that feeds the ALU in the Tomasulo-style out-of-order core; it is the issuing side of the ALU interface.
- Accepts decoded ALU/branch instructions from dispatch and buffers them until both operands are ready.
- Snoops the ALU and LSB result buses (CDB) to capture operand values.
- Issues one ready instruction per cycle to the ALU through registered outputs: status, OpCode, rs1, rs2, ROB_Number.

---
 rtl/alu_rs.sv | 153 +++++++++++++++
 1 files changed

// File: rtl/alu_rs.sv
// rtl/alu_rs.sv - ALU reservation station: buffers dispatched ops, snoops both CDBs,
// issues the lowest-index ready entry each enabled cycle through registered outputs.
module alu_rs #(
  parameter int RS_SIZE = 16,
  parameter int OP_W    = 6,
  parameter int ROB_W   = 4
) (
  input  logic             clk_in,
  input  logic             rst_in,
  input  logic             rdy_in,
  input  logic             clear,
  input  logic             dsp_valid,
  input  logic [OP_W-1:0]  dsp_op,
  input  logic [31:0]      dsp_vj,
  input  logic [ROB_W-1:0] dsp_qj,
  input  logic             dsp_qj_pend,
  input  logic [31:0]      dsp_vk,
  input  logic [ROB_W-1:0] dsp_qk,
  input  logic             dsp_qk_pend,
  input  logic [ROB_W-1:0] dsp_rob,
  input  logic             alu_cdb_valid,
  input  logic [ROB_W-1:0] alu_cdb_rob,
  input  logic [31:0]      alu_cdb_val,
  input  logic             lsb_cdb_valid,
  input  logic [ROB_W-1:0] lsb_cdb_rob,
  input  logic [31:0]      lsb_cdb_val,
  output logic             full,
  output logic             status,
  output logic [OP_W-1:0]  OpCode,
  output logic [31:0]      rs1,
  output logic [31:0]      rs2,
  output logic [ROB_W-1:0] ROB_Number
);
  localparam int IDX_W = $clog2(RS_SIZE);

  logic [RS_SIZE-1:0] r_busy, r_pj, r_pk;
  logic [OP_W-1:0]    r_op  [RS_SIZE];
  logic [31:0]        r_vj  [RS_SIZE];
  logic [31:0]        r_vk  [RS_SIZE];
  logic [ROB_W-1:0]   r_qj  [RS_SIZE];
  logic [ROB_W-1:0]   r_qk  [RS_SIZE];
  logic [ROB_W-1:0]   r_rob [RS_SIZE];

  logic             w_free_found, w_iss_found;
  logic [IDX_W-1:0] w_free_idx, w_iss_idx;
  logic [32:0]      w_j_snp [RS_SIZE];
  logic [32:0]      w_k_snp [RS_SIZE];
  logic [32:0]      w_dj_snp, w_dk_snp;

  // {hit, value}; the ALU bus wins if both buses carry the same tag
  function automatic logic [32:0] snoop(input logic [ROB_W-1:0] tag);
    logic [32:0] res;
    res = '0;
    if (alu_cdb_valid && alu_cdb_rob == tag)      res = {1'b1, alu_cdb_val};
    else if (lsb_cdb_valid && lsb_cdb_rob == tag) res = {1'b1, lsb_cdb_val};
    return res;
  endfunction

  // descending scan so the lowest matching index is the one left standing
  always_comb begin
    w_free_found = 1'b0;
    w_free_idx   = '0;
    w_iss_found  = 1'b0;
    w_iss_idx    = '0;
    w_dj_snp     = snoop(dsp_qj);
    w_dk_snp     = snoop(dsp_qk);
    for (int i = RS_SIZE - 1; i >= 0; i--) begin
      w_j_snp[i] = snoop(r_qj[i]);
      w_k_snp[i] = snoop(r_qk[i]);
      if (!r_busy[i]) begin
        w_free_found = 1'b1;
        w_free_idx   = IDX_W'(i);
      end
      if (r_busy[i] && !r_pj[i] && !r_pk[i]) begin
        w_iss_found = 1'b1;
        w_iss_idx   = IDX_W'(i);
      end
    end
  end

  assign full = !w_free_found;

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      r_busy     <= '0;
      r_pj       <= '0;
      r_pk       <= '0;
      status     <= 1'b0;
      OpCode     <= '0;
      rs1        <= '0;
      rs2        <= '0;
      ROB_Number <= '0;
      for (int i = 0; i < RS_SIZE; i++) begin
        r_op[i]  <= '0;
        r_vj[i]  <= '0;
        r_vk[i]  <= '0;
        r_qj[i]  <= '0;
        r_qk[i]  <= '0;
        r_rob[i] <= '0;
      end
    end else if (rdy_in) begin
      if (clear) begin
        r_busy <= '0;
        status <= 1'b0;
      end else begin
        for (int i = 0; i < RS_SIZE; i++) begin
          if (r_busy[i] && r_pj[i] && w_j_snp[i][32]) begin
            r_vj[i] <= w_j_snp[i][31:0];
            r_pj[i] <= 1'b0;
          end
          if (r_busy[i] && r_pk[i] && w_k_snp[i][32]) begin
            r_vk[i] <= w_k_snp[i][31:0];
            r_pk[i] <= 1'b0;
          end
        end

        if (w_iss_found) begin
          status            <= 1'b1;
          OpCode            <= r_op[w_iss_idx];
          rs1               <= r_vj[w_iss_idx];
          rs2               <= r_vk[w_iss_idx];
          ROB_Number        <= r_rob[w_iss_idx];
          r_busy[w_iss_idx] <= 1'b0;
        end else begin
          status <= 1'b0;
        end

        // the free slot is never the issuing slot, so the two writes cannot collide
        if (dsp_valid && w_free_found) begin
          r_busy[w_free_idx] <= 1'b1;
          r_op[w_free_idx]   <= dsp_op;
          r_rob[w_free_idx]  <= dsp_rob;
          r_qj[w_free_idx]   <= dsp_qj;
          r_qk[w_free_idx]   <= dsp_qk;
          if (dsp_qj_pend && w_dj_snp[32]) begin
            r_vj[w_free_idx] <= w_dj_snp[31:0];
            r_pj[w_free_idx] <= 1'b0;
          end else begin
            r_vj[w_free_idx] <= dsp_vj;
            r_pj[w_free_idx] <= dsp_qj_pend;
          end
          if (dsp_qk_pend && w_dk_snp[32]) begin
            r_vk[w_free_idx] <= w_dk_snp[31:0];
            r_pk[w_free_idx] <= 1'b0;
          end else begin
            r_vk[w_free_idx] <= dsp_vk;
            r_pk[w_free_idx] <= dsp_qk_pend;
          end
        end
      end
    end
  end
endmodule
